// File: rtl/pll_seq_pkg.sv
// Shared types and default constants for the PLL reset/lock sequencer.
package pll_seq_pkg;

    typedef enum logic [2:0] {
        PLL_RST   = 3'd0,
        WAIT_LOCK = 3'd1,
        STABLE    = 3'd2,
        RUN       = 3'd3,
        FAIL      = 3'd4
    } pll_seq_state_t;

    localparam int unsigned STATE_W  = 3;
    localparam int unsigned RELOCK_W = 8;

    localparam int unsigned DEF_RST_PULSE_CYC    = 16;
    localparam int unsigned DEF_LOCK_TIMEOUT_CYC = 50000;
    localparam int unsigned DEF_LOCK_STABLE_CYC  = 1024;
    localparam int unsigned DEF_MAX_RETRIES      = 7;
    localparam int unsigned DEF_CNT_W            = 16;

    // Retry counter must hold MAX_RETRIES and is never narrower than 3 bits.
    function automatic int unsigned retry_width(input int unsigned max_retries);
        int unsigned w;
        w = $clog2(max_retries + 1);
        return (w < 3) ? 32'd3 : w;
    endfunction

endpackage

// File: rtl/pll_lock_sequencer_if.sv
// Control/status bundle between the sequencer and the PLL / reset tree.
interface pll_lock_sequencer_if;
    import pll_seq_pkg::*;

    logic                locked;
    logic                req_reconfig;
    logic                pll_rst;
    logic                sys_rst;
    logic                ready;
    logic                fail;
    logic [STATE_W-1:0]  state;
    logic [RELOCK_W-1:0] relock_count;

    modport master (
        input  locked, req_reconfig,
        output pll_rst, sys_rst, ready, fail, state, relock_count
    );

    modport slave (
        output locked, req_reconfig,
        input  pll_rst, sys_rst, ready, fail, state, relock_count
    );

endinterface

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level signal.
module sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/pll_lock_sequencer.sv
// PLL reset/lock supervisor: pulses the PLL reset, qualifies lock, releases the
// system reset, re-sequences on lock loss or request, and latches FAIL on timeouts.
module pll_lock_sequencer
    import pll_seq_pkg::*;
#(
    parameter int unsigned RST_PULSE_CYC    = DEF_RST_PULSE_CYC,
    parameter int unsigned LOCK_TIMEOUT_CYC = DEF_LOCK_TIMEOUT_CYC,
    parameter int unsigned LOCK_STABLE_CYC  = DEF_LOCK_STABLE_CYC,
    parameter int unsigned MAX_RETRIES      = DEF_MAX_RETRIES,
    parameter int unsigned CNT_W            = DEF_CNT_W
) (
    input  logic                 refclk,
    input  logic                 rst,
    pll_lock_sequencer_if.master bus
);

    localparam int unsigned RETRY_W = retry_width(MAX_RETRIES);

    localparam logic [CNT_W-1:0]    RST_LAST     = CNT_W'(RST_PULSE_CYC - 1);
    localparam logic [CNT_W-1:0]    TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYC - 1);
    localparam logic [CNT_W-1:0]    STABLE_LAST  = CNT_W'(LOCK_STABLE_CYC - 1);
    localparam logic [RETRY_W-1:0]  RETRY_MAX    = RETRY_W'(MAX_RETRIES);
    localparam logic [RELOCK_W-1:0] RELOCK_MAX   = '1;

    pll_seq_state_t      state_q;
    pll_seq_state_t      state_nx;
    logic [CNT_W-1:0]    timer_q;
    logic [RETRY_W-1:0]  retry_q;
    logic [RETRY_W-1:0]  retry_nx;
    logic [RELOCK_W-1:0] relock_q;
    logic                lock_s;
    logic                restart_c;
    logic                lock_lost_c;
    logic                pll_rst_q;
    logic                sys_rst_q;
    logic                ready_q;
    logic                fail_q;

    sync_2ff u_lock_sync (
        .clk (refclk),
        .rst (rst),
        .d   (bus.locked),
        .q   (lock_s)
    );

    // Next-state and retry decisions; a reconfig request overrides everything.
    always_comb begin
        state_nx    = state_q;
        retry_nx    = retry_q;
        restart_c   = 1'b0;
        lock_lost_c = (state_q == RUN) && !lock_s;

        if (bus.req_reconfig) begin
            state_nx  = PLL_RST;
            retry_nx  = '0;
            restart_c = 1'b1;
        end else begin
            case (state_q)
                PLL_RST: begin
                    if (timer_q == RST_LAST) state_nx = WAIT_LOCK;
                end
                WAIT_LOCK: begin
                    if (lock_s) begin
                        state_nx = STABLE;
                    end else if (timer_q == TIMEOUT_LAST) begin
                        if (retry_q == RETRY_MAX) begin
                            state_nx = FAIL;
                        end else begin
                            state_nx = PLL_RST;
                            retry_nx = retry_q + RETRY_W'(1);
                        end
                    end
                end
                STABLE: begin
                    if (!lock_s) begin
                        state_nx = WAIT_LOCK;
                    end else if (timer_q == STABLE_LAST) begin
                        state_nx = RUN;
                        retry_nx = '0;
                    end
                end
                RUN: begin
                    if (!lock_s) state_nx = PLL_RST;
                end
                FAIL: begin
                    state_nx = FAIL;
                end
                default: begin
                    state_nx = PLL_RST;
                end
            endcase
        end
    end

    // State, timer and counters; outputs decoded from next state so they move with it.
    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            state_q   <= PLL_RST;
            timer_q   <= '0;
            retry_q   <= '0;
            relock_q  <= '0;
            pll_rst_q <= 1'b1;
            sys_rst_q <= 1'b1;
            ready_q   <= 1'b0;
            fail_q    <= 1'b0;
        end else begin
            state_q   <= state_nx;
            retry_q   <= retry_nx;
            timer_q   <= (restart_c || (state_nx != state_q)) ? '0 : timer_q + CNT_W'(1);
            if (lock_lost_c && (relock_q != RELOCK_MAX)) begin
                relock_q <= relock_q + RELOCK_W'(1);
            end
            pll_rst_q <= (state_nx == PLL_RST);
            sys_rst_q <= (state_nx != RUN);
            ready_q   <= (state_nx == RUN);
            fail_q    <= (state_nx == FAIL);
        end
    end

    assign bus.pll_rst      = pll_rst_q;
    assign bus.sys_rst      = sys_rst_q;
    assign bus.ready        = ready_q;
    assign bus.fail         = fail_q;
    assign bus.state        = state_q;
    assign bus.relock_count = relock_q;

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Scoreboard bench for pll_lock_sequencer: a phase/countdown reference model
// predicts every cycle's outputs; a negedge monitor compares them.
module tb_pll_lock_sequencer;
    import pll_seq_pkg::*;

    localparam int RST_PULSE_CYC    = 4;
    localparam int LOCK_TIMEOUT_CYC = 20;
    localparam int LOCK_STABLE_CYC  = 8;
    localparam int MAX_RETRIES      = 2;
    localparam int CNT_W            = 16;

    localparam int S_PLL_RST = 0;
    localparam int S_WAIT    = 1;
    localparam int S_STABLE  = 2;
    localparam int S_RUN     = 3;
    localparam int S_FAIL    = 4;

    typedef struct {
        bit pll_rst;
        bit sys_rst;
        bit ready;
        bit fail;
        int state;
        int relock;
    } obs_t;

    logic refclk = 1'b0;
    logic rst    = 1'b1;
    logic locked = 1'b0;
    logic req    = 1'b0;

    int n_cmp = 0;
    int n_err = 0;

    pll_lock_sequencer_if bus ();
    assign bus.locked       = locked;
    assign bus.req_reconfig = req;

    pll_lock_sequencer #(
        .RST_PULSE_CYC    (RST_PULSE_CYC),
        .LOCK_TIMEOUT_CYC (LOCK_TIMEOUT_CYC),
        .LOCK_STABLE_CYC  (LOCK_STABLE_CYC),
        .MAX_RETRIES      (MAX_RETRIES),
        .CNT_W            (CNT_W)
    ) dut (
        .refclk (refclk),
        .rst    (rst),
        .bus    (bus.master)
    );

    always #10 refclk = ~refclk;

    // ---------------- reference model ----------------
    int   ph;
    int   left;
    int   timeouts;
    int   m_relock;
    bit   ls;
    bit   pipe[$];
    obs_t exp_q[$];

    function automatic int span(input int p);
        case (p)
            S_PLL_RST: return RST_PULSE_CYC;
            S_WAIT:    return LOCK_TIMEOUT_CYC;
            S_STABLE:  return LOCK_STABLE_CYC;
            default:   return 0;
        endcase
    endfunction

    function automatic obs_t expect_for(input int p, input int rc);
        obs_t e;
        e.pll_rst = (p == S_PLL_RST);
        e.sys_rst = (p != S_RUN);
        e.ready   = (p == S_RUN);
        e.fail    = (p == S_FAIL);
        e.state   = p;
        e.relock  = rc;
        return e;
    endfunction

    task automatic enter(input int p);
        ph   = p;
        left = span(p);
    endtask

    task automatic count_relock();
        if (m_relock < 255) m_relock++;
    endtask

    initial forever begin
        @(posedge refclk);
        if (rst) begin
            timeouts = 0;
            m_relock = 0;
            pipe     = {};
            pipe.push_back(1'b0);
            pipe.push_back(1'b0);
            enter(S_PLL_RST);
        end else begin
            // lock as seen by the sequencer lags the pin by two samples
            ls = pipe.pop_front();
            pipe.push_back(locked);
            if (req) begin
                if (ph == S_RUN && !ls) count_relock();
                timeouts = 0;
                enter(S_PLL_RST);
            end else begin
                case (ph)
                    S_PLL_RST: begin
                        left--;
                        if (left == 0) enter(S_WAIT);
                    end
                    S_WAIT: begin
                        if (ls) enter(S_STABLE);
                        else begin
                            left--;
                            if (left == 0) begin
                                timeouts++;
                                if (timeouts > MAX_RETRIES) enter(S_FAIL);
                                else enter(S_PLL_RST);
                            end
                        end
                    end
                    S_STABLE: begin
                        if (!ls) enter(S_WAIT);
                        else begin
                            left--;
                            if (left == 0) begin
                                timeouts = 0;
                                enter(S_RUN);
                            end
                        end
                    end
                    S_RUN: begin
                        if (!ls) begin
                            count_relock();
                            enter(S_PLL_RST);
                        end
                    end
                    default: ;
                endcase
            end
        end
        exp_q.push_back(expect_for(ph, m_relock));
    end

    // ---------------- checking ----------------
    task automatic check(input string name, input int act, input int req_v);
        n_cmp++;
        if (act != req_v) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req_v, $time);
        end
    endtask

    task automatic check_obs(input obs_t a, input obs_t e);
        n_cmp++;
        if (a.pll_rst != e.pll_rst || a.sys_rst != e.sys_rst || a.ready != e.ready ||
            a.fail != e.fail || a.state != e.state || a.relock != e.relock) begin
            n_err++;
            $display("FAIL scoreboard t=%0t: got pll_rst=%0d sys_rst=%0d ready=%0d fail=%0d state=%0d relock=%0d, expected pll_rst=%0d sys_rst=%0d ready=%0d fail=%0d state=%0d relock=%0d",
                     $time, a.pll_rst, a.sys_rst, a.ready, a.fail, a.state, a.relock,
                     e.pll_rst, e.sys_rst, e.ready, e.fail, e.state, e.relock);
        end
    endtask

    initial forever begin
        @(negedge refclk);
        if (exp_q.size() > 0) begin
            obs_t e;
            obs_t a;
            e = exp_q.pop_front();
            // an asynchronous reset asserted since the last edge overrides the prediction
            if (rst) e = expect_for(S_PLL_RST, 0);
            a.pll_rst = bus.pll_rst;
            a.sys_rst = bus.sys_rst;
            a.ready   = bus.ready;
            a.fail    = bus.fail;
            a.state   = int'(bus.state);
            a.relock  = int'(bus.relock_count);
            check_obs(a, e);
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge refclk);
            #1;
        end
    endtask

    task automatic pulse_req();
        req = 1'b1;
        tick(1);
        req = 1'b0;
    endtask

    task automatic wait_state(input string name, input int st, input int max_cyc);
        int n;
        n = 0;
        while (int'(bus.state) != st && n < max_cyc) begin
            tick(1);
            n++;
        end
        check(name, int'(bus.state), st);
    endtask

    initial begin
        int n;
        int hi;
        int pulses;
        bit prev;

        tick(3);
        check("reset pll_rst", bus.pll_rst, 1);
        check("reset sys_rst", bus.sys_rst, 1);
        check("reset state", int'(bus.state), S_PLL_RST);

        // power-up: pulse length, then lock-to-ready latency
        rst = 1'b0;
        n = 0;
        do begin tick(1); n++; end while (bus.pll_rst && n < 50);
        check("pll_rst pulse length", n, RST_PULSE_CYC);
        tick(4);
        locked = 1'b1;
        n = 0;
        do begin tick(1); n++; end while (!bus.ready && n < 100);
        check("lock-to-ready edges", n - 1, 2 + LOCK_STABLE_CYC);
        check("relock after power-up", int'(bus.relock_count), 0);

        // one-cycle lock drop in STABLE at timer 5
        pulse_req();
        wait_state("enter STABLE", S_STABLE, 20);
        tick(5);
        locked = 1'b0;
        tick(1);
        locked = 1'b1;
        wait_state("drop returns to WAIT_LOCK", S_WAIT, 4);
        n = 0;
        do begin tick(1); n++; end while (!bus.ready && n < 40);
        check("WAIT_LOCK-to-ready edges after drop", n, 1 + LOCK_STABLE_CYC);

        // repeated timeouts end in FAIL
        locked = 1'b0;
        pulse_req();
        hi = 1; pulses = 1; prev = 1'b1; n = 0;
        while (!bus.fail && n < 200) begin
            tick(1);
            n++;
            if (bus.pll_rst) begin
                hi++;
                if (!prev) pulses++;
            end
            prev = bus.pll_rst;
        end
        check("edges to FAIL", n, (RST_PULSE_CYC + LOCK_TIMEOUT_CYC) * (MAX_RETRIES + 1));
        check("pll_rst pulses before FAIL", pulses, MAX_RETRIES + 1);
        check("pll_rst high cycles before FAIL", hi, RST_PULSE_CYC * (MAX_RETRIES + 1));
        tick(30);
        check("FAIL is terminal", int'(bus.state), S_FAIL);
        check("pll_rst low in FAIL", bus.pll_rst, 0);

        // recovery from FAIL
        locked = 1'b1;
        pulse_req();
        check("fail cleared by reconfig", bus.fail, 0);
        check("reconfig enters PLL_RST", int'(bus.state), S_PLL_RST);
        wait_state("RUN after recovery", S_RUN, 40);

        // three lock losses in RUN
        for (int k = 0; k < 3; k++) begin
            locked = 1'b0;
            tick(1);
            locked = 1'b1;
            tick(1);
            check("ready still high at f1", bus.ready, 1);
            tick(1);
            check("sys_rst at f2", bus.sys_rst, 1);
            check("pll_rst at f2", bus.pll_rst, 1);
            wait_state("RUN after relock", S_RUN, 40);
        end
        check("relock_count after 3 losses", int'(bus.relock_count), 3);

        // randomized lock chatter and reconfig requests
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 15) == 0) locked = ~locked;
            req = ($urandom_range(0, 63) == 0);
            tick(1);
        end
        req = 1'b0;
        locked = 1'b1;
        pulse_req();
        wait_state("RUN after random phase", S_RUN, 40);

        // relock counter saturation
        for (int k = 0; k < 300; k++) begin
            locked = 1'b0;
            tick(1);
            locked = 1'b1;
            tick(2);
            wait_state("RUN in saturation loop", S_RUN, 40);
        end
        check("relock_count saturates", int'(bus.relock_count), 255);

        // asynchronous reset in the middle of STABLE
        pulse_req();
        wait_state("STABLE before async reset", S_STABLE, 20);
        tick(3);
        #5;
        rst = 1'b1;
        #1;
        check("async rst pll_rst", bus.pll_rst, 1);
        check("async rst sys_rst", bus.sys_rst, 1);
        check("async rst ready", bus.ready, 0);
        check("async rst fail", bus.fail, 0);
        check("async rst state", int'(bus.state), S_PLL_RST);
        check("async rst relock_count", int'(bus.relock_count), 0);
        tick(2);
        rst = 1'b0;
        wait_state("RUN after async reset", S_RUN, 40);

        tick(3);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
